alu_issue_capture: RTL and testbench

- Sequential wrapper stage on both sides of the 32-bit gate-level ALU (3-bit command; carry/overflow/zero flags).
- Upstream side: accepts an operand/command transaction over valid/ready and registers it onto the ALU inputs.
- Holds those inputs stable for a fixed settle window covering the ALU's gate-delay ripple, then captures result and flags.
- Downstream side: presents the captured result to the consumer over valid/ready.

---
 rtl/alu_issue_capture_pkg.sv | 33 +++
 rtl/alu_issue_capture_if.sv | 45 ++++
 rtl/alu_issue_capture_settle_timer.sv | 27 ++
 rtl/alu_issue_capture.sv | 98 +++++++++
 tb/tb_alu_issue_capture.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_capture_pkg.sv
// Shared constants for the ALU issue/capture stage: data width, ALU command
// map, FSM state encodings and the flag-masking helpers.
package alu_issue_capture_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_XOR  = 3'd2,
    OP_SLT  = 3'd3,
    OP_AND  = 3'd4,
    OP_NAND = 3'd5,
    OP_NOR  = 3'd6,
    OP_OR   = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    HOLD   = 2'd2
  } state_e;

  // Carry only means something for the arithmetic commands.
  function automatic logic carry_used(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

  function automatic logic overflow_used(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_SLT);
  endfunction

endpackage

// File: rtl/alu_issue_capture_if.sv
// Bundle of upstream, ALU-facing and downstream signals of the capture stage.
// slave is the stage itself; master is whatever surrounds it.
interface alu_issue_capture_if #(parameter int STAT_W = 16);
  import alu_issue_capture_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_a;
  logic [DATA_W-1:0] in_b;
  logic [2:0]        in_op;

  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [2:0]        alu_sel;
  logic [DATA_W-1:0] alu_out;
  logic              alu_carry;
  logic              alu_overflow;
  logic              alu_zero;

  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_result;
  logic              out_carry;
  logic              out_overflow;
  logic              out_zero;
  logic [2:0]        out_op;
  logic [STAT_W-1:0] stat_ops;

  modport slave (
    input  in_valid, in_a, in_b, in_op,
    input  alu_out, alu_carry, alu_overflow, alu_zero,
    input  out_ready,
    output in_ready, alu_a, alu_b, alu_sel,
    output out_valid, out_result, out_carry, out_overflow, out_zero, out_op, stat_ops
  );

  modport master (
    output in_valid, in_a, in_b, in_op,
    output alu_out, alu_carry, alu_overflow, alu_zero,
    output out_ready,
    input  in_ready, alu_a, alu_b, alu_sel,
    input  out_valid, out_result, out_carry, out_overflow, out_zero, out_op, stat_ops
  );

endinterface

// File: rtl/alu_issue_capture_settle_timer.sv
// Loadable down-counter that stops at zero; done marks the end of the
// window the ALU inputs must be held for.
module alu_issue_capture_settle_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/alu_issue_capture.sv
// Registers a transaction onto the gate-level ALU, waits out its ripple delay,
// captures result and masked flags, and hands them downstream over valid/ready.
module alu_issue_capture
  import alu_issue_capture_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8,
  parameter int STAT_W        = 16
) (
  input logic                clk,
  input logic                reset,
  alu_issue_capture_if.slave bus
);

  state_e            state;
  logic [DATA_W-1:0] alu_a_q;
  logic [DATA_W-1:0] alu_b_q;
  logic [2:0]        alu_sel_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_result_q;
  logic              out_carry_q;
  logic              out_overflow_q;
  logic              out_zero_q;
  logic [2:0]        out_op_q;
  logic [STAT_W-1:0] stat_q;
  logic              accept;
  logic              timer_done;

  // Ready depends only on state and the consumer, so a retire can overlap the next accept.
  assign bus.in_ready = (state == IDLE) || ((state == HOLD) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  alu_issue_capture_settle_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (accept),
    .load_val (CNT_W'(SETTLE_CYCLES - 1)),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      alu_sel_q      <= '0;
      out_valid_q    <= 1'b0;
      out_result_q   <= '0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
      out_op_q       <= '0;
      stat_q         <= '0;
    end else begin
      if (accept) begin
        alu_a_q   <= bus.in_a;
        alu_b_q   <= bus.in_b;
        alu_sel_q <= bus.in_op;
      end
      case (state)
        IDLE: begin
          if (accept) state <= SETTLE;
        end
        SETTLE: begin
          if (timer_done) begin
            out_result_q   <= bus.alu_out;
            out_carry_q    <= bus.alu_carry & carry_used(alu_sel_q);
            out_overflow_q <= bus.alu_overflow & overflow_used(alu_sel_q);
            out_zero_q     <= bus.alu_zero;
            out_op_q       <= alu_sel_q;
            out_valid_q    <= 1'b1;
            state          <= HOLD;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            stat_q      <= stat_q + STAT_W'(1);
            state       <= bus.in_valid ? SETTLE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_sel      = alu_sel_q;
  assign bus.out_valid    = out_valid_q;
  assign bus.out_result   = out_result_q;
  assign bus.out_carry    = out_carry_q;
  assign bus.out_overflow = out_overflow_q;
  assign bus.out_zero     = out_zero_q;
  assign bus.out_op       = out_op_q;
  assign bus.stat_ops     = stat_q;

endmodule

// File: tb/tb_alu_issue_capture.sv
// Directed bench for alu_issue_capture: a 4-cycle/16-bit-stat build and a
// 1-cycle/4-bit-stat build, each driven against a behavioural ALU stub.
module tb_alu_issue_capture;
  import alu_issue_capture_pkg::*;

  logic clk;
  logic reset;
  logic stub_carry;
  logic stub_overflow;
  int   n_vec;
  int   n_miss;
  int   lat;

  alu_issue_capture_if #(.STAT_W(16)) bus4 ();
  alu_issue_capture_if #(.STAT_W(4))  bus1 ();

  alu_issue_capture #(.SETTLE_CYCLES(4), .CNT_W(8), .STAT_W(16)) dut4 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus4)
  );

  alu_issue_capture #(.SETTLE_CYCLES(1), .CNT_W(8), .STAT_W(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] op);
    case (op)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a ^ b;
      3'd3: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd4: return a & b;
      3'd5: return ~(a & b);
      3'd6: return ~(a | b);
      default: return a | b;
    endcase
  endfunction

  // ALU stub: result computed from the registered inputs, carry/overflow forced by the bench.
  always_comb begin
    bus4.alu_out      = alu_model(bus4.alu_a, bus4.alu_b, bus4.alu_sel);
    bus4.alu_carry    = stub_carry;
    bus4.alu_overflow = stub_overflow;
    bus4.alu_zero     = (bus4.alu_out == 32'd0);
    bus1.alu_out      = alu_model(bus1.alu_a, bus1.alu_b, bus1.alu_sel);
    bus1.alu_carry    = stub_carry;
    bus1.alu_overflow = stub_overflow;
    bus1.alu_zero     = (bus1.alu_out == 32'd0);
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_miss++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a negedge; leaves in_valid low at the negedge after the accept edge.
  task automatic applyStimulus(input bit which, input logic [31:0] a, input logic [31:0] b,
                               input logic [2:0] op);
    if (which) begin
      bus1.in_valid = 1'b1; bus1.in_a = a; bus1.in_b = b; bus1.in_op = op;
    end else begin
      bus4.in_valid = 1'b1; bus4.in_a = a; bus4.in_b = b; bus4.in_op = op;
    end
    @(posedge clk);
    @(negedge clk);
    bus1.in_valid = 1'b0;
    bus4.in_valid = 1'b0;
  endtask

  task automatic waitValid(input bit which, output int cycles);
    cycles = 0;
    while (cycles < 20) begin
      @(posedge clk);
      @(negedge clk);
      cycles++;
      if ((which ? bus1.out_valid : bus4.out_valid) === 1'b1) break;
    end
  endtask

  task automatic retire(input bit which);
    if (which) bus1.out_ready = 1'b1; else bus4.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus1.out_ready = 1'b0;
    bus4.out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    n_vec = 0; n_miss = 0;
    stub_carry = 1'b0; stub_overflow = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_a = '0; bus4.in_b = '0; bus4.in_op = '0; bus4.out_ready = 1'b0;
    bus1.in_valid = 1'b0; bus1.in_a = '0; bus1.in_b = '0; bus1.in_op = '0; bus1.out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_in_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_alu_a", bus4.alu_a, 32'd0);
    checkOutput("rst_out_result", bus4.out_result, 32'd0);
    checkOutput("rst_stat_ops", 32'(bus4.stat_ops), 32'd0);
    reset = 1'b0;

    // ADD 10+1
    applyStimulus(1'b0, 32'd10, 32'd1, OP_ADD);
    waitValid(1'b0, lat);
    checkOutput("add_latency", 32'(lat), 32'd4);
    checkOutput("add_result", bus4.out_result, 32'd11);
    checkOutput("add_carry", 32'(bus4.out_carry), 32'd0);
    checkOutput("add_overflow", 32'(bus4.out_overflow), 32'd0);
    checkOutput("add_zero", 32'(bus4.out_zero), 32'd0);
    checkOutput("add_op", 32'(bus4.out_op), 32'd0);
    checkOutput("hold_in_ready", 32'(bus4.in_ready), 32'd0);
    retire(1'b0);
    checkOutput("add_retired_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("add_stat", 32'(bus4.stat_ops), 32'd1);

    // SUB 0-1
    applyStimulus(1'b0, 32'd0, 32'd1, OP_SUB);
    waitValid(1'b0, lat);
    checkOutput("sub_result", bus4.out_result, 32'hFFFF_FFFF);
    checkOutput("sub_carry", 32'(bus4.out_carry), 32'd0);
    checkOutput("sub_overflow", 32'(bus4.out_overflow), 32'd0);
    checkOutput("sub_op", 32'(bus4.out_op), 32'd1);
    retire(1'b0);

    // XOR 1^1 with forced flags: carry/overflow masked, zero passes
    stub_carry = 1'b1; stub_overflow = 1'b1;
    applyStimulus(1'b0, 32'd1, 32'd1, OP_XOR);
    waitValid(1'b0, lat);
    checkOutput("xor_result", bus4.out_result, 32'd0);
    checkOutput("xor_carry", 32'(bus4.out_carry), 32'd0);
    checkOutput("xor_overflow", 32'(bus4.out_overflow), 32'd0);
    checkOutput("xor_zero", 32'(bus4.out_zero), 32'd1);
    retire(1'b0);

    // SLT keeps overflow but masks carry
    applyStimulus(1'b0, 32'hFFFF_FFFF, 32'd1, OP_SLT);
    waitValid(1'b0, lat);
    checkOutput("slt_result", bus4.out_result, 32'd1);
    checkOutput("slt_carry", 32'(bus4.out_carry), 32'd0);
    checkOutput("slt_overflow", 32'(bus4.out_overflow), 32'd1);
    retire(1'b0);
    checkOutput("slt_stat", 32'(bus4.stat_ops), 32'd4);
    stub_carry = 1'b0; stub_overflow = 1'b0;

    // Backpressure with a competing upstream request
    applyStimulus(1'b0, 32'h0000_F0F0, 32'h0000_FF00, OP_AND);
    waitValid(1'b0, lat);
    bus4.in_valid = 1'b1; bus4.in_a = 32'hDEAD_BEEF; bus4.in_b = 32'd5; bus4.in_op = OP_OR;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("bp_out_valid", 32'(bus4.out_valid), 32'd1);
    checkOutput("bp_result", bus4.out_result, 32'h0000_F000);
    checkOutput("bp_op", 32'(bus4.out_op), 32'd4);
    checkOutput("bp_in_ready", 32'(bus4.in_ready), 32'd0);
    checkOutput("bp_alu_a", bus4.alu_a, 32'h0000_F0F0);
    checkOutput("bp_stat", 32'(bus4.stat_ops), 32'd4);
    bus4.in_valid = 1'b0;
    retire(1'b0);
    checkOutput("bp_retired_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("bp_retired_stat", 32'(bus4.stat_ops), 32'd5);
    checkOutput("bp_idle_in_ready", 32'(bus4.in_ready), 32'd1);
    checkOutput("bp_idle_alu_a", bus4.alu_a, 32'h0000_F0F0);

    // out_ready with nothing held must not count
    bus4.out_ready = 1'b1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
    end
    bus4.out_ready = 1'b0;
    checkOutput("idle_ready_stat", 32'(bus4.stat_ops), 32'd5);

    // Back-to-back from a fresh reset: ADD 1+2, SUB 5-3, OR 7|7
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1; bus4.in_a = 32'd1; bus4.in_b = 32'd2; bus4.in_op = OP_ADD;
    @(posedge clk);
    @(negedge clk);
    waitValid(1'b0, lat);
    checkOutput("b2b0_latency", 32'(lat), 32'd4);
    checkOutput("b2b0_result", bus4.out_result, 32'd3);
    checkOutput("b2b0_in_ready", 32'(bus4.in_ready), 32'd1);
    bus4.in_a = 32'd5; bus4.in_b = 32'd3; bus4.in_op = OP_SUB;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b0_no_bubble", 32'(bus4.in_ready), 32'd0);
    checkOutput("b2b1_alu_a", bus4.alu_a, 32'd5);
    waitValid(1'b0, lat);
    checkOutput("b2b1_latency", 32'(lat), 32'd4);
    checkOutput("b2b1_result", bus4.out_result, 32'd2);
    bus4.in_a = 32'd7; bus4.in_b = 32'd7; bus4.in_op = OP_OR;
    @(posedge clk);
    @(negedge clk);
    checkOutput("b2b1_no_bubble", 32'(bus4.out_valid), 32'd0);
    checkOutput("b2b2_alu_sel", 32'(bus4.alu_sel), 32'd7);
    waitValid(1'b0, lat);
    checkOutput("b2b2_latency", 32'(lat), 32'd4);
    checkOutput("b2b2_result", bus4.out_result, 32'd7);
    bus4.in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus4.out_ready = 1'b0;
    checkOutput("b2b_stat", 32'(bus4.stat_ops), 32'd3);
    checkOutput("b2b_idle", 32'(bus4.in_ready), 32'd1);

    // Reset two cycles into SETTLE drops the transaction
    applyStimulus(1'b0, 32'd3, 32'd4, OP_ADD);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_mid_out_valid", 32'(bus4.out_valid), 32'd0);
    checkOutput("rst_mid_alu_a", bus4.alu_a, 32'd0);
    checkOutput("rst_mid_out_result", bus4.out_result, 32'd0);
    checkOutput("rst_mid_stat", 32'(bus4.stat_ops), 32'd0);
    checkOutput("rst_mid_in_ready", 32'(bus4.in_ready), 32'd1);
    repeat (6) begin
      @(posedge clk);
      @(negedge clk);
    end
    checkOutput("rst_mid_dropped", 32'(bus4.out_valid), 32'd0);

    // SETTLE_CYCLES=1 build: single-cycle latency and 4-bit stat wrap
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 32'(i), 32'd1, OP_ADD);
      waitValid(1'b1, lat);
      checkOutput("s1_latency", 32'(lat), 32'd1);
      checkOutput("s1_result", bus1.out_result, 32'(i + 1));
      retire(1'b1);
      if (i == 14) checkOutput("s1_stat_15", 32'(bus1.stat_ops), 32'd15);
    end
    checkOutput("s1_stat_wrap", 32'(bus1.stat_ops), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
